// File: rtl/obi_arb_pkg.sv
// Shared types and sizing helpers for the OBI data-port arbiter and its ID FIFO.
package obi_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Bits needed to index n items, never less than one so a 1-entry structure still has a field.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted master indices; the head names the master owed the next response.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot a simultaneous push needs, so push at full is fine when popping.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // NOTE: every variable of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count and pointers decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_data_arbiter.sv
// N:1 OBI data-port arbiter: round-robin or fixed priority, address-phase lock, in-order response routing.
module obi_data_arbiter
  import obi_arb_pkg::*;
#(
  parameter int        NUM_MASTERS     = 2,
  parameter int        ADDR_WIDTH      = 32,
  parameter int        DATA_WIDTH      = 32,
  parameter int        MAX_OUTSTANDING = 2,
  parameter arb_mode_e ARB_MODE        = ARB_RR
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NUM_MASTERS-1:0]                   m_req_i,
  output logic [NUM_MASTERS-1:0]                   m_gnt_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]                   m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]                   m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    m_rdata_o,
  output logic                                     s_req_o,
  output logic [ADDR_WIDTH-1:0]                    s_addr_o,
  output logic                                     s_we_o,
  output logic [DATA_WIDTH/8-1:0]                  s_be_o,
  output logic [DATA_WIDTH-1:0]                    s_wdata_o,
  input  logic                                     s_gnt_i,
  input  logic                                     s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
  output logic                                     err_o
);

  localparam int IDX_W = clog2_min1(NUM_MASTERS);
  localparam int CNT_W = clog2_min1(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] arb_idx, winner, fifo_head;
  logic             arb_found, lock_hold, proto_err;
  logic             handshake, id_full, resp_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  int               cand;

  // Search from rr_ptr in round-robin mode, from index 0 in fixed-priority mode.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = i;
      if (ARB_MODE == ARB_RR) begin
        cand = int'(rr_ptr_q) + i;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      end
      if (!arb_found && m_req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  // A locked master keeps the address phase; dropping its request is a protocol error that frees it.
  assign lock_hold  = lock_q & m_req_i[lock_idx_q];
  assign proto_err  = lock_q & ~m_req_i[lock_idx_q];
  assign winner     = lock_hold ? lock_idx_q : arb_idx;

  assign id_full    = fifo_full & ~s_rvalid_i;
  assign s_req_o    = arb_found & ~id_full & ~rst_i;
  assign handshake  = s_req_o & s_gnt_i;
  assign resp_valid = s_rvalid_i & ~fifo_empty & ~rst_i;

  assign s_addr_o   = rst_i ? '0 : m_addr_i[winner];
  assign s_we_o     = rst_i ? 1'b0 : m_we_i[winner];
  assign s_be_o     = rst_i ? '0 : m_be_i[winner];
  assign s_wdata_o  = rst_i ? '0 : m_wdata_i[winner];
  assign m_rdata_o  = rst_i ? '0 : s_rdata_i;
  assign err_o      = err_q;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_gnt_o[i]    = handshake & (winner == IDX_W'(i));
      m_rvalid_o[i] = resp_valid & (fifo_head == IDX_W'(i));
    end
  end

  always_comb begin
    lock_d     = lock_hold;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q | proto_err | (s_rvalid_i & fifo_empty);
    if (handshake) begin
      lock_d = 1'b0;
      if (ARB_MODE == ARB_RR) begin
        rr_ptr_d = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
      end
    end else if (s_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .pop_i   (s_rvalid_i),
    .data_i  (winner),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  outstanding_bound_a : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Directed bench: a default round-robin instance plus a 3-master fixed-priority instance.
module tb_obi_data_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance (default parameters)
  logic [1:0]        req, gnt, rvalid;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0]        we;
  logic [1:0][3:0]   be;
  logic [31:0]       rdata, s_addr, s_wdata, s_rdata;
  logic              s_req, s_we, s_gnt, s_rvalid, err;
  logic [3:0]        s_be;

  // Fixed-priority instance
  logic [2:0]        fx_req, fx_gnt, fx_rvalid, fx_we;
  logic [2:0][31:0]  fx_addr, fx_wdata;
  logic [2:0][3:0]   fx_be;
  logic [31:0]       fx_rdata, fx_s_addr, fx_s_wdata, fx_s_rdata;
  logic              fx_s_req, fx_s_we, fx_s_gnt, fx_s_rvalid, fx_err;
  logic [3:0]        fx_s_be;

  int n_checks = 0;
  int n_pass   = 0;

  obi_data_arbiter dut_rr (
    .clk_i (clk), .rst_i (rst),
    .m_req_i (req), .m_gnt_o (gnt),
    .m_addr_i (addr), .m_we_i (we), .m_be_i (be), .m_wdata_i (wdata),
    .m_rvalid_o (rvalid), .m_rdata_o (rdata),
    .s_req_o (s_req), .s_addr_o (s_addr), .s_we_o (s_we), .s_be_o (s_be), .s_wdata_o (s_wdata),
    .s_gnt_i (s_gnt), .s_rvalid_i (s_rvalid), .s_rdata_i (s_rdata),
    .err_o (err)
  );

  obi_data_arbiter #(
    .NUM_MASTERS (3),
    .ARB_MODE    (obi_arb_pkg::ARB_FIXED)
  ) dut_fx (
    .clk_i (clk), .rst_i (rst),
    .m_req_i (fx_req), .m_gnt_o (fx_gnt),
    .m_addr_i (fx_addr), .m_we_i (fx_we), .m_be_i (fx_be), .m_wdata_i (fx_wdata),
    .m_rvalid_o (fx_rvalid), .m_rdata_o (fx_rdata),
    .s_req_o (fx_s_req), .s_addr_o (fx_s_addr), .s_we_o (fx_s_we), .s_be_o (fx_s_be),
    .s_wdata_o (fx_s_wdata),
    .s_gnt_i (fx_s_gnt), .s_rvalid_i (fx_s_rvalid), .s_rdata_i (fx_s_rdata),
    .err_o (fx_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [1:0] exp_gnt [4];
  logic [1:0] exp_rv  [4];

  initial begin
    rst = 1'b1;
    addr  = '{32'h2000_0004, 32'h1000_0000};
    wdata = '{32'hBBBB_1111, 32'hAAAA_0000};
    we    = 2'b10;
    be    = '{4'h3, 4'hF};
    fx_addr  = '{32'h3000_0020, 32'h3000_0010, 32'h3000_0000};
    fx_wdata = '0;
    fx_we    = '0;
    fx_be    = '{4'h1, 4'h2, 4'h4};
    fx_s_rdata = 32'h5555_0000;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};

    // Reset: every output is 0 even with live inputs
    req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF;
    fx_req = 3'b111; fx_s_gnt = 1'b1; fx_s_rvalid = 1'b1;
    sample();
    check("rst_s_req", s_req, 0);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_err", err, 0);
    check("rst_fx_s_req", fx_s_req, 0);

    // Round-robin alternation with rvalid one cycle after each grant
    next_cycle();
    rst = 1'b0; fx_req = '0; fx_s_rvalid = 1'b0; fx_s_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_rvalid = (c > 0);
      s_rdata  = 32'hD000_0000 + c;
      sample();
      check($sformatf("rr_gnt_%0d", c), gnt, exp_gnt[c]);
      check($sformatf("rr_rvalid_%0d", c), rvalid, exp_rv[c]);
      check($sformatf("rr_addr_%0d", c), s_addr, (c % 2 == 0) ? 32'h1000_0000 : 32'h2000_0004);
      if (c == 1) begin
        check("rr_we_m1", s_we, 1);
        check("rr_be_m1", s_be, 4'h3);
        check("rr_wdata_m1", s_wdata, 32'hBBBB_1111);
        check("rr_rdata", rdata, 32'hD000_0001);
      end
      next_cycle();
    end
    req = 2'b00; s_rvalid = 1'b1;
    sample();
    check("rr_last_rvalid", rvalid, 2'b10);
    check("rr_idle_s_req", s_req, 0);

    // Lock: master 1 waits 3 cycles without grant while master 0 joins
    next_cycle();
    s_rvalid = 1'b0; s_gnt = 1'b0; req = 2'b10;
    sample();
    check("lock_s_req", s_req, 1);
    check("lock_gnt_a", gnt, 0);
    check("lock_addr_a", s_addr, 32'h2000_0004);
    next_cycle();
    req = 2'b11;
    for (int c = 0; c < 2; c++) begin
      sample();
      check($sformatf("lock_addr_hold_%0d", c), s_addr, 32'h2000_0004);
      check($sformatf("lock_gnt_hold_%0d", c), gnt, 0);
      next_cycle();
    end
    s_gnt = 1'b1;
    sample();
    check("lock_gnt_m1", gnt, 2'b10);
    check("lock_addr_m1", s_addr, 32'h2000_0004);
    next_cycle();
    sample();
    check("lock_next_m0", gnt, 2'b01);
    check("lock_next_addr", s_addr, 32'h1000_0000);

    // Full at 2 outstanding; pop and push in the same cycle keep the count at 2
    next_cycle();
    sample();
    check("full_s_req", s_req, 0);
    check("full_gnt", gnt, 0);
    next_cycle();
    s_rvalid = 1'b1; s_rdata = 32'hE100_0001;
    sample();
    check("full_pp_s_req", s_req, 1);
    check("full_pp_gnt", gnt, 2'b10);
    check("full_pp_rvalid", rvalid, 2'b10);
    check("full_pp_rdata", rdata, 32'hE100_0001);
    next_cycle();
    s_rvalid = 1'b0;
    sample();
    check("full_still", s_req, 0);
    next_cycle();
    req = 2'b00; s_rvalid = 1'b1;
    sample();
    check("drain_0", rvalid, 2'b01);
    next_cycle();
    sample();
    check("drain_1", rvalid, 2'b10);
    next_cycle();
    s_rvalid = 1'b0;
    sample();
    check("drain_err", err, 0);

    // Locked master drops its request without a grant
    s_gnt = 1'b0; req = 2'b01;
    next_cycle();
    req = 2'b00;
    sample();
    check("drop_err_pre", err, 0);
    next_cycle();
    sample();
    check("drop_err", err, 1);
    check("drop_s_req", s_req, 0);
    rst = 1'b1;
    sample();
    check("drop_rst_err", err, 0);
    next_cycle();
    rst = 1'b0;

    // Response with an empty FIFO
    s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD;
    sample();
    check("empty_rvalid", rvalid, 0);
    check("empty_err_pre", err, 0);
    next_cycle();
    s_rvalid = 1'b0;
    sample();
    check("empty_err", err, 1);
    next_cycle();
    sample();
    check("empty_err_held", err, 1);

    // Reset with 2 outstanding, rr_ptr left at 1
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; req = 2'b11; s_gnt = 1'b1;
    sample();
    check("ro_gnt_a", gnt, 2'b01);
    next_cycle();
    req = 2'b01;
    sample();
    check("ro_gnt_b", gnt, 2'b01);
    next_cycle();
    rst = 1'b1; req = 2'b11; s_rvalid = 1'b1;
    sample();
    check("ro_rst_s_req", s_req, 0);
    check("ro_rst_gnt", gnt, 0);
    check("ro_rst_rvalid", rvalid, 0);
    next_cycle();
    rst = 1'b0; req = 2'b00;
    sample();
    check("ro_stale_rvalid", rvalid, 0);
    next_cycle();
    s_rvalid = 1'b0; req = 2'b11;
    sample();
    check("ro_stale_err", err, 1);
    check("ro_ptr_zero", gnt, 2'b01);
    next_cycle();
    sample();
    check("ro_count_1", s_req, 1);
    check("ro_gnt_m1", gnt, 2'b10);
    next_cycle();
    sample();
    check("ro_count_2", s_req, 0);
    next_cycle();
    req = 2'b00; s_gnt = 1'b0;

    // Fixed priority: master 0 takes every grant
    fx_req = 3'b111; fx_s_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fx_s_rvalid = (c > 0);
      sample();
      check($sformatf("fx_gnt_%0d", c), fx_gnt, 3'b001);
      check($sformatf("fx_rvalid_%0d", c), fx_rvalid, (c > 0) ? 3'b001 : 3'b000);
      next_cycle();
    end
    fx_s_rvalid = 1'b0; fx_s_gnt = 1'b0; fx_req = 3'b110;
    sample();
    check("fx_lock_addr", fx_s_addr, 32'h3000_0010);
    next_cycle();
    fx_req = 3'b111;
    sample();
    check("fx_lock_hold", fx_s_addr, 32'h3000_0010);
    check("fx_lock_gnt0", fx_gnt, 0);
    next_cycle();
    fx_s_gnt = 1'b1;
    sample();
    check("fx_lock_gnt", fx_gnt, 3'b010);
    check("fx_lock_be", fx_s_be, 4'h2);
    check("fx_err", fx_err, 0);
    next_cycle();
    fx_req = '0; fx_s_gnt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
